// File: rtl/ram_sp_clr.sv
// Synchronous single-port RAM with byte enables, registered read and a
// hardware sweep that fills the whole array with INIT_VAL after reset or on request.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_CLEAR | writing INIT_VAL to mem[clr_ptr] each cycle, accesses gated
// ST_IDLE  | ready=1, reads/writes accepted, clr_req sampled
module ram_sp_clr #(
   parameter int            DW       = 8,
   parameter int            AW       = 10,
   parameter int            DEPTH    = 1024,
   parameter logic [DW-1:0] INIT_VAL = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cs,
   input  logic            wr,
   input  logic [AW-1:0]   addr,
   input  logic [DW-1:0]   data_in,
   input  logic [DW/8-1:0] be,
   input  logic            clr_req,
   output logic [DW-1:0]   data_out,
   output logic            rd_valid,
   output logic            ready
);

   localparam int          NB       = DW / 8;
   localparam int          LAST     = DEPTH - 1;
   localparam logic [AW:0] LAST_PTR = LAST[AW:0];
   localparam logic [AW:0] DEPTH_W  = DEPTH[AW:0];
   localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

   typedef enum logic {
      ST_CLEAR,
      ST_IDLE
   } state_t;

   state_t        state, state_nxt;
   logic [AW:0]   clr_ptr, ptr_nxt;
   logic          in_range;
   logic          wr_en;
   logic          rd_en;
   logic          clr_we;
   logic [DW-1:0] mem [0:DEPTH-1];

   // One extra address bit keeps the compare correct when DEPTH == 2**AW.
   assign in_range = ({1'b0, addr} < DEPTH_W);
   assign wr_en    = ready & cs & wr & in_range;
   assign rd_en    = ready & cs & ~wr;
   assign clr_we   = (state == ST_CLEAR);

   always_comb begin
      state_nxt = state;
      ptr_nxt   = clr_ptr;
      unique case (state)
         ST_CLEAR: begin
            if (clr_ptr == LAST_PTR) begin
               state_nxt = ST_IDLE;
               ptr_nxt   = '0;
            end else begin
               ptr_nxt = clr_ptr + PTR_ONE;
            end
         end
         ST_IDLE: begin
            if (clr_req) begin
               state_nxt = ST_CLEAR;
               ptr_nxt   = '0;
            end
         end
         default: begin
            state_nxt = ST_CLEAR;
            ptr_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_CLEAR;
         clr_ptr  <= '0;
         ready    <= 1'b0;
         rd_valid <= 1'b0;
         data_out <= '0;
      end else begin
         state    <= state_nxt;
         clr_ptr  <= ptr_nxt;
         ready    <= (state_nxt == ST_IDLE);
         rd_valid <= rd_en;
         if (rd_en) begin
            data_out <= in_range ? mem[addr] : INIT_VAL;
         end
      end
   end

   // Array is left untouched during a reset cycle; the sweep that follows rewrites it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (clr_we) begin
            mem[clr_ptr[AW-1:0]] <= INIT_VAL;
         end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
               if (be[i]) begin
                  mem[addr][8*i +: 8] <= data_in[8*i +: 8];
               end
            end
         end
      end
   end

endmodule

// File: doc/ram_sp_clr.md
Name: ram_sp_clr

Overview:
- Parametrised synchronous single-port RAM. Successor to the asynchronous 1024x8 chip-select memory.
- Adds a clock, generic width and depth, and byte enables.
- Reads are registered, with a one-cycle read-valid strobe.
- A hardware clear engine sweeps the whole array to INIT_VAL after reset or on request. It serves as the scratch/buffer store for datapath blocks.

Parameters:
- DW, 8, data width in bits; must be a multiple of 8.
- AW, 10, address width.
- DEPTH, 1024, number of words; must satisfy 2 <= DEPTH <= 2**AW.
- INIT_VAL, 0, DW-bit value written to every word by the clear engine.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- cs  in  1  chip select; an access occurs only when cs=1 and ready=1.
- wr  in  1  1=write, 0=read; qualified by cs.
- addr  in  AW  word address.
- data_in  in  DW  write data.
- be  in  DW/8  byte enables for writes; bit i covers data_in[8i+7:8i].
- clr_req  in  1  pulse to start a full-array clear.
- data_out  out  DW  registered read data.
- rd_valid  out  1  one-cycle strobe; data_out is new this cycle.
- ready  out  1  1 = accesses accepted; 0 while clearing.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state<=CLEAR, clr_ptr<=0, data_out<=0, rd_valid<=0, ready<=0.
  - Array contents are not touched during the rst cycle.
  - Reset mid-clear or mid-access restarts the clear from address 0.
- State CLEAR:
  - Each cycle writes INIT_VAL to mem[clr_ptr], then clr_ptr<=clr_ptr+1.
  - When clr_ptr==DEPTH-1, the last word is written and the next state is IDLE.
  - ready<=1 registered, so ready is high in the cycle after the last clear write.
  - Clear time is exactly DEPTH cycles from the first cycle with rst=0 to ready=1.
  - cs, wr, and clr_req are ignored while ready=0: no write, no read, rd_valid stays 0.
- State IDLE (ready=1):
  - Write (cs=1, wr=1): for each i with be[i]=1, mem[addr][8i+7:8i]<=data_in[8i+7:8i]. Bytes with be=0 are unchanged; be=0 means no change at all.
  - Read (cs=1, wr=0): data_out<=mem[addr] and rd_valid<=1 on the next edge (latency 1). be is ignored on reads.
  - cs=0: no access; rd_valid<=0.
  - data_out holds its last value until the next read; it is never cleared except by rst.
  - Back-to-back reads on consecutive cycles produce a rd_valid high on consecutive cycles, each with its own data.
  - A read immediately after a write to the same address returns the new data.
- Out-of-range addresses (addr>=DEPTH, possible only when DEPTH<2**AW):
  - Writes are dropped.
  - Reads return INIT_VAL with rd_valid=1.
- clr_req:
  - Sampled only in IDLE.
  - If it arrives together with cs, the access in that cycle completes normally. ready<=0 and state<=CLEAR on the same edge; sweeping begins the next cycle from address 0.
  - clr_req held high for multiple cycles starts one clear; re-arming requires clr_req seen in IDLE again.
  - rst takes priority over clr_req.
- Outputs and width rules:
  - No combinational path from inputs to outputs.
  - Address arithmetic is AW+1 bits internally, so DEPTH=2**AW never wraps early.

Test Plan:
1. Power-up clear: rst=1 for 2 cycles, then 0 with defaults -> ready=0 for exactly 1024 cycles, then 1. Reads of addr 0, 511, and 1023 return 8'h00 with rd_valid=1 one cycle after each request.
2. Write/read pattern: for k=0..15, write data_in=(2k)%256 to addr=k, then read addr 0..15 -> data_out=2k, rd_valid pulses once per read, latency 1. The cycle after the last read has rd_valid=0 and data_out holding 30.
3. Byte enables (DW=32): write 32'hAABBCCDD to addr 5 with be=4'hF, then 32'h11223344 with be=4'b0101 -> read returns 32'hAA22CC44. A write with be=0 leaves the word unchanged.
4. Gated accesses: cs=1 with wr=1, addr=3, data_in=8'h5A issued while ready=0 -> no rd_valid, and addr 3 reads 8'h00 after the clear. cs=0 with wr=1 in IDLE -> memory unchanged.
5. Clear request: fill addr 0..15, then pulse clr_req together with a read of addr 7 -> that read returns 8'h0E. ready drops for 1024 cycles, after which addr 7 reads INIT_VAL. A clr_req pulse during the clear does not extend it.
6. Reset mid-clear and odd depth: assert rst at clear cycle 500 -> ready rises 1024 cycles after rst deasserts. With DEPTH=1000, a write to addr 1010 is dropped and a read of addr 1010 returns INIT_VAL with rd_valid=1.
